// File: rtl/rng_share_ctrl_if.sv
// rtl/rng_share_ctrl_if.sv - request/grant/word bundle for the shared RNG server
//
// Ports (slave view, i.e. the server side):
//   req       in  N   level request lines, one per consumer
//   seed_load in  1   load seed into the generator (only acted on while idle)
//   seed      in  26  seed value, seed[i-1] -> state bit s[i]
//   gnt       out N   one-hot grant, only alongside valid
//   valid     out 1   one-cycle word strobe
//   data      out W   random word, data[i] = s[i+1]
//   busy      out 1   a transaction is in flight
`timescale 1ns/1ps
interface rng_share_ctrl_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic [N-1:0]  req;
  logic          seed_load;
  logic [25:0]   seed;
  logic [N-1:0]  gnt;
  logic          valid;
  logic [W-1:0]  data;
  logic          busy;

  modport master (
    output req, seed_load, seed,
    input  gnt, valid, data, busy
  );

  modport slave (
    input  req, seed_load, seed,
    output gnt, valid, data, busy
  );
endinterface

// File: rtl/rng_share_ctrl.sv
// rtl/rng_share_ctrl.sv - round-robin server for a shared 26-bit Galois LFSR
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of rng_share_ctrl_if (req/seed_load/seed in,
//          gnt/valid/data/busy out)
//
// Each accepted request advances the generator STEPS times and then presents
// one W-bit word for a single cycle together with the requester's grant.
`timescale 1ns/1ps
module rng_share_ctrl #(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int STEPS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  rng_share_ctrl_if.slave  bus
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_OUT  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [25:0]     s_q, s_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   win_q, win_d;
  logic [7:0]      cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic [N-1:0]    gnt_q, gnt_d;

  logic [25:0]     s_step;
  logic [PW-1:0]   rr_win;
  logic            rr_any;
  int              rr_idx;

  // Stored bit k holds s[k+1]. Feedback from s26 is folded into s1, s2,
  // s8 and s9; everything else shifts up by one.
  always_comb begin
    s_step        = '0;
    s_step[0]     = s_q[25];
    s_step[1]     = s_q[0] ^ s_q[25];
    s_step[6:2]   = s_q[5:1];
    s_step[7]     = s_q[6] ^ s_q[25];
    s_step[8]     = s_q[7] ^ s_q[25];
    s_step[25:9]  = s_q[24:8];
  end

  // Round-robin pick: walk offsets from the far end down to ptr itself so
  // the requester closest to ptr (wrapping upward) is the last one written.
  always_comb begin
    rr_win = ptr_q;
    rr_any = 1'b0;
    rr_idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      rr_idx = int'(ptr_q) + k;
      if (rr_idx >= N) rr_idx = rr_idx - N;
      if (bus.req[rr_idx[PW-1:0]]) begin
        rr_win = rr_idx[PW-1:0];
        rr_any = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    cnt_d   = cnt_q;
    valid_d = 1'b0;
    gnt_d   = '0;
    case (state_q)
      ST_IDLE: begin
        // Seed wins over a same-cycle request; the request is looked at
        // again next cycle against the freshly loaded state.
        if (bus.seed_load) begin
          s_d = (bus.seed == 26'd0) ? 26'h1 : bus.seed;
        end else if (rr_any) begin
          win_d   = rr_win;
          cnt_d   = 8'(STEPS);
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        s_d   = s_step;
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd1) begin
          state_d = ST_OUT;
          valid_d = 1'b1;
          gnt_d   = {{(N-1){1'b0}}, 1'b1} << win_q;
        end
      end
      ST_OUT: begin
        ptr_d   = (win_q == PW'(N - 1)) ? '0 : win_q + PW'(1);
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      s_q     <= 26'h1;
      ptr_q   <= '0;
      win_q   <= '0;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      gnt_q   <= gnt_d;
    end
  end

  assign bus.valid = valid_q;
  assign bus.gnt   = gnt_q;
  assign bus.data  = s_q[W-1:0];
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_rng_share_ctrl.sv
// tb/tb_rng_share_ctrl.sv - bench for rng_share_ctrl at STEPS = 1, 4 and 8
//
// Three instances share one stimulus stream; each has a transaction-level
// reference model and all outputs are compared on every falling edge.
`timescale 1ns/1ps
module tb_rng_share_ctrl;
  localparam int N = 4;
  localparam int W = 16;
  localparam int L = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  req = '0;
  logic          seed_load = 1'b0;
  logic [25:0]   seed = '0;

  int checks = 0;
  int errors = 0;

  logic          l_valid[L], l_busy[L], e_valid[L], e_busy[L];
  logic [N-1:0]  l_gnt[L], e_gnt[L];
  logic [W-1:0]  l_data[L], e_data[L];

  always #5 clk = ~clk;

  // Multiply-by-x modulo the generator polynomial: x^26 folds onto 1,x,x^7,x^8.
  function automatic logic [25:0] advance(input logic [25:0] s, input int n);
    logic [25:0] v;
    v = s;
    for (int i = 0; i < n; i++)
      v = v[25] ? ({v[24:0], 1'b0} ^ 26'h0000183) : {v[24:0], 1'b0};
    return v;
  endfunction

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++)
      if (r[(p + k) % N]) return (p + k) % N;
    return 0;
  endfunction

  task automatic chk(input string nm, input int g, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s lane%0d: got %0h expected %0h at %0t", nm, g, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < L; g++) begin : g_lane
    localparam int S = (g == 0) ? 1 : (g == 1) ? 4 : 8;

    rng_share_ctrl_if #(.N(N), .W(W)) u_if ();

    assign u_if.req       = req;
    assign u_if.seed_load = seed_load;
    assign u_if.seed      = seed;

    rng_share_ctrl #(.N(N), .W(W), .STEPS(S)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave)
    );

    logic [25:0]  m_s;
    logic [W-1:0] m_word;
    int           m_ptr, m_left, m_win;

    // m_left counts cycles until the server is free again; the word is on
    // the bus during the last of them.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_s    <= 26'h1;
        m_ptr  <= 0;
        m_left <= 0;
        m_win  <= 0;
        m_word <= '0;
      end else if (m_left == 0) begin
        if (seed_load) begin
          m_s <= (seed == 26'd0) ? 26'h1 : seed;
        end else if (req != '0) begin
          m_win  <= pick(req, m_ptr);
          m_s    <= advance(m_s, S);
          m_word <= W'(advance(m_s, S));
          m_left <= S + 1;
        end
      end else begin
        if (m_left == 1) m_ptr <= (m_win + 1) % N;
        m_left <= m_left - 1;
      end
    end

    assign l_valid[g] = u_if.valid;
    assign l_busy[g]  = u_if.busy;
    assign l_gnt[g]   = u_if.gnt;
    assign l_data[g]  = u_if.data;
    assign e_valid[g] = (m_left == 1);
    assign e_busy[g]  = (m_left != 0);
    assign e_gnt[g]   = (m_left == 1) ? ({{(N-1){1'b0}}, 1'b1} << m_win) : '0;
    assign e_data[g]  = m_word;
  end

  always @(negedge clk) begin
    for (int g = 0; g < L; g++) begin
      chk("valid", g, 32'(l_valid[g]), 32'(e_valid[g]));
      chk("gnt",   g, 32'(l_gnt[g]),   32'(e_gnt[g]));
      chk("busy",  g, 32'(l_busy[g]),  32'(e_busy[g]));
      if (e_valid[g]) chk("data", g, 32'(l_data[g]), 32'(e_data[g]));
    end
  end

  logic [W-1:0] f_data[L];
  logic [N-1:0] f_gnt[L];
  int           f_lat[L];

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [25:0] sd);
    @(negedge clk);
    seed_load = 1'b1;
    seed      = sd;
    @(negedge clk);
    seed_load = 1'b0;
  endtask

  // Holds req until every lane has shown a first word, records it, then
  // drops req and lets all lanes drain back to idle.
  task automatic run_req(input logic [N-1:0] r);
    bit seen[L];
    int cyc;
    for (int g = 0; g < L; g++) seen[g] = 1'b0;
    req = r;
    cyc = 0;
    while (!(seen[0] && seen[1] && seen[2]) && cyc < 100) begin
      @(negedge clk);
      cyc++;
      for (int g = 0; g < L; g++)
        if (!seen[g] && l_valid[g]) begin
          seen[g]  = 1'b1;
          f_data[g] = l_data[g];
          f_gnt[g]  = l_gnt[g];
          f_lat[g]  = cyc;
        end
    end
    req = '0;
    for (int g = 0; g < L; g++) chk("word_seen", g, 32'(seen[g]), 32'd1);
    repeat (12) @(negedge clk);
  endtask

  initial begin
    logic [N-1:0] exp_g[5];
    logic [N-1:0] got_g[5];
    int           got_c[5];
    int           nv, cyc;

    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    @(negedge clk);
    for (int g = 0; g < L; g++) begin
      chk("rst_data",  g, 32'(l_data[g]),  32'h0001);
      chk("rst_valid", g, 32'(l_valid[g]), 32'd0);
      chk("rst_gnt",   g, 32'(l_gnt[g]),   32'd0);
      chk("rst_busy",  g, 32'(l_busy[g]),  32'd0);
    end
    rst_n = 1'b1;

    load(26'h1);
    run_req(4'b0001);
    chk("s1_data", 0, 32'(f_data[0]), 32'h0002);
    chk("s1_gnt",  0, 32'(f_gnt[0]),  32'h1);
    chk("s1_lat",  0, f_lat[0], 2);
    chk("s4_data", 1, 32'(f_data[1]), 32'h0010);
    chk("s8_data", 2, 32'(f_data[2]), 32'h0100);
    chk("s8_lat",  2, f_lat[2], 9);

    load(26'h2000000);
    run_req(4'b0010);
    chk("top_data", 0, 32'(f_data[0]), 32'h0183);
    chk("top_gnt",  0, 32'(f_gnt[0]),  32'h2);

    load(26'h0);
    run_req(4'b0100);
    chk("zero_seed_data", 1, 32'(f_data[1]), 32'h0010);
    chk("zero_seed_gnt",  1, 32'(f_gnt[1]),  32'h4);

    do_reset();
    req = 4'b1111;
    nv  = 0;
    cyc = 0;
    while (nv < 5 && cyc < 80) begin
      @(negedge clk);
      cyc++;
      if (l_valid[1]) begin
        got_g[nv] = l_gnt[1];
        got_c[nv] = cyc;
        nv++;
      end
    end
    req = '0;
    chk("rr_count", 1, nv, 5);
    for (int i = 0; i < 5; i++) begin
      if (i < nv) begin
        chk("rr_order", 1, 32'(got_g[i]), 32'(exp_g[i]));
        if (i > 0) chk("rr_gap", 1, got_c[i] - got_c[i-1], 6);
      end
    end
    repeat (12) @(negedge clk);

    seed_load = 1'b1;
    seed      = 26'h1;
    req       = 4'b0001;
    @(negedge clk);
    seed_load = 1'b0;
    chk("seed_prio_busy", 0, 32'(l_busy[0]), 32'd0);
    run_req(4'b0001);
    chk("seed_prio_lat",  0, f_lat[0], 2);
    chk("seed_prio_data", 0, 32'(f_data[0]), 32'h0002);
    chk("seed_prio_data", 2, 32'(f_data[2]), 32'h0100);

    do_reset();
    req = 4'b0001;
    @(negedge clk);
    seed_load = 1'b1;
    seed      = 26'h155;
    @(negedge clk);
    seed_load = 1'b0;
    run_req(4'b0001);
    chk("run_seed_ignored", 1, 32'(f_data[1]), 32'h0010);
    chk("run_seed_ignored", 2, 32'(f_data[2]), 32'h0100);

    do_reset();
    req = 4'b0001;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", 2, 32'(l_busy[2]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    for (int g = 0; g < L; g++) begin
      chk("mid_rst_busy",  g, 32'(l_busy[g]),  32'd0);
      chk("mid_rst_valid", g, 32'(l_valid[g]), 32'd0);
      chk("mid_rst_data",  g, 32'(l_data[g]),  32'h0001);
    end
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    run_req(4'b0001);
    chk("post_rst_data", 2, 32'(f_data[2]), 32'h0100);

    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      req       = N'($urandom);
      seed_load = ($urandom_range(0, 7) == 0);
      seed      = ($urandom_range(0, 3) == 0) ? 26'h0 : 26'($urandom);
      if ($urandom_range(0, 199) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end
    end
    req       = '0;
    seed_load = 1'b0;
    repeat (12) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rng_share_ctrl.md
# rng_share_ctrl

Shared pseudo-random word server. The block owns a 26-bit Galois LFSR and its sequencing, and arbitrates it round-robin among N requesters. For each granted request it seeds or advances the generator a fixed number of steps, then returns one W-bit word. It sits between the game/stimulus logic that consumes random numbers and the single generator resource.

## Interface
- N, 4: number of requesters (2..8)
- W, 16: returned word width (1..26)
- STEPS, 8: LFSR steps per delivered word (1..255)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req  in  N  request lines, level; held until own gnt bit seen with valid
- seed_load  in  1  load seed into LFSR (honoured only in IDLE)
- seed  in  26  seed value; seed[i-1] maps to state bit s[i]
- gnt  out  N  one-hot grant, asserted only with valid
- valid  out  1  one-cycle word strobe
- data  out  W  random word; data[i] = s[i+1]
- busy  out  1  high in RUN or OUT

## Operation
- State s[1:26]. One step (all simultaneous): s1'=s26; s2'=s1^s26; s3..s7' = s2..s6; s8'=s7^s26; s9'=s8^s26; s10..s26' = s9..s25.
- The state never holds zero. A seed of 0 loads 26'h1.
- FSM: IDLE, RUN, OUT.
- IDLE: no stepping.
  - If seed_load=1, load seed this edge, stay IDLE. The seed has priority over req in the same cycle; req is re-evaluated next cycle.
  - Else if req!=0, pick the winner by round-robin: search from ptr upward, wrapping. Latch the winner index, set cnt=STEPS, go RUN.
- RUN: step once per cycle; cnt decrements. On the cycle cnt==1, step and go OUT.
- OUT: valid=1, gnt=onehot(winner), data from the current state, no step. ptr <= (winner+1) mod N. Go IDLE.
- seed_load in RUN or OUT is ignored (not queued).
- A req change after the grant decision does not cancel the transaction; the word is still delivered.
- ptr resets to 0 and changes only in OUT.

## Timing
- Reset values (asynchronous, immediate): state=IDLE, s=26'h1, ptr=0, cnt=0, valid=0, gnt=0, data=s-derived (0x0001 for W=16), busy=0.
- Req sampled in IDLE at cycle t: RUN during t+1..t+STEPS, valid/gnt at t+STEPS+1, IDLE at t+STEPS+2.
- Throughput is 1 word per STEPS+2 cycles. There are no back-to-back grants; at least one IDLE cycle separates them.
- data is a function of s at all times. It is only meaningful while valid=1.
- If rst_n is asserted mid-RUN or mid-OUT, the block returns to IDLE with s=1 and ptr=0; the pending word is lost and no valid is emitted.
- A seed loaded at edge e is the stepping base for any request accepted at edge e+1 or later.

## Test plan
- Reset, then N=4, W=16, STEPS=1, seed_load with seed=26'h1, then req=4'b0001 -> valid one cycle at t+2, gnt=0001, data=16'h0002, busy high for 2 cycles.
- seed=26'h2000000, STEPS=1, req=0010 -> data=16'h0183 (s1,s2,s8,s9 set), gnt=0010.
- seed=0, STEPS=4, one request -> the state is treated as 1, so data=16'h0010.
- req=4'b1111 held continuously -> grants in order 0001, 0010, 0100, 1000, 0001. The gap between valids is exactly STEPS+2 cycles.
- seed_load and req asserted in the same IDLE cycle -> seed loaded, RUN starts one cycle later. seed_load pulsed during RUN -> ignored; the word matches the unseeded sequence.
- rst_n pulsed low during RUN -> outputs drop immediately, no valid. The next request after reset yields the same word as from a fresh reset (STEPS=8, seed 1: data=16'h0100).
